uart_csr_bridge: RTL

- CPU-facing register bridge that sits directly upstream and downstream of the UART core.
- Presents a small byte-wide register bus to a softcore/SoC.
- Buffers outgoing bytes in a TX FIFO that drives the core's TX valid/ready input. Buffers incoming bytes from the core's RX valid/ready output in an RX FIFO.
- Provides status, level, sticky error flags and an interrupt line.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync_fifo.sv | 67 ++++++
 rtl/uart_csr_bridge.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map and bit positions shared by the UART CSR bridge
package uart_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_STATUS   = 3'd1;
    localparam logic [2:0] ADDR_CTRL     = 3'd2;
    localparam logic [2:0] ADDR_TX_LEVEL = 3'd3;
    localparam logic [2:0] ADDR_RX_LEVEL = 3'd4;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_RX_FULL     = 2;
    localparam int ST_RX_EMPTY    = 3;
    localparam int ST_RX_OVERRUN  = 4;
    localparam int ST_TX_OVERFLOW = 5;

    localparam int CTRL_CLR_OVERRUN  = 0;
    localparam int CTRL_CLR_OVERFLOW = 1;
    localparam int CTRL_FLUSH_TX     = 2;
    localparam int CTRL_FLUSH_RX     = 3;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word-fall-through synchronous FIFO with flush
module uart_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = CNT_W - 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_csr_bridge.sv
// rtl/uart_csr_bridge.sv - byte-wide CPU register bridge with TX/RX FIFOs around a UART core
module uart_csr_bridge
    import uart_pkg::*;
#(
    parameter  int FIFO_DEPTH = 16,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] addr,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       irq,
    output logic [7:0] uart_tx_data,
    output logic       uart_tx_valid,
    input  logic       uart_tx_ready,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_valid,
    output logic       uart_rx_ready
);

    logic             w_wr_data;
    logic             w_wr_ctrl;
    logic             w_rd_data;
    logic             w_tx_flush;
    logic             w_rx_flush;
    logic             w_tx_pop;
    logic             w_rx_push;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic [CNT_W-1:0] w_tx_count;
    logic [CNT_W-1:0] w_rx_count;
    logic [7:0]       w_tx_dout;
    logic [7:0]       w_rx_dout;
    logic             w_ovf_set;
    logic             w_ovr_set;
    logic [7:0]       w_status;
    logic [7:0]       w_rd_mux;

    logic             r_tx_overflow;
    logic             r_rx_overrun;
    logic [7:0]       r_rdata;
    logic             r_rdata_valid;

    assign w_wr_data  = wr_en & (addr == ADDR_DATA);
    assign w_wr_ctrl  = wr_en & (addr == ADDR_CTRL);
    assign w_rd_data  = rd_en & (addr == ADDR_DATA);
    assign w_tx_flush = w_wr_ctrl & wdata[CTRL_FLUSH_TX];
    assign w_rx_flush = w_wr_ctrl & wdata[CTRL_FLUSH_RX];

    assign uart_rx_ready = rst;
    assign uart_tx_valid = ~w_tx_empty;
    assign uart_tx_data  = w_tx_dout;
    assign w_tx_pop      = uart_tx_valid & uart_tx_ready;
    assign w_rx_push     = uart_rx_valid & uart_rx_ready;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_wr_data),
        .pop   (uart_tx_ready),
        .flush (w_tx_flush),
        .din   (wdata),
        .dout  (w_tx_dout),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push),
        .pop   (w_rd_data),
        .flush (w_rx_flush),
        .din   (uart_rx_data),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    // A flush discards the byte silently, so it suppresses the drop flags.
    assign w_ovf_set = w_wr_data & w_tx_full & ~w_tx_pop & ~w_tx_flush;
    assign w_ovr_set = w_rx_push & w_rx_full & ~w_rd_data & ~w_rx_flush;

    always_comb begin
        w_status                 = '0;
        w_status[ST_TX_FULL]     = w_tx_full;
        w_status[ST_TX_EMPTY]    = w_tx_empty;
        w_status[ST_RX_FULL]     = w_rx_full;
        w_status[ST_RX_EMPTY]    = w_rx_empty;
        w_status[ST_RX_OVERRUN]  = r_rx_overrun;
        w_status[ST_TX_OVERFLOW] = r_tx_overflow;
    end

    always_comb begin
        w_rd_mux = '0;
        case (addr)
            ADDR_DATA:     w_rd_mux = w_rx_empty ? 8'h00 : w_rx_dout;
            ADDR_STATUS:   w_rd_mux = w_status;
            ADDR_TX_LEVEL: w_rd_mux = 8'(w_tx_count);
            ADDR_RX_LEVEL: w_rd_mux = 8'(w_rx_count);
            default:       w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_overflow <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_tx_overflow <= w_ovf_set | (r_tx_overflow & ~(w_wr_ctrl & wdata[CTRL_CLR_OVERFLOW]));
            r_rx_overrun  <= w_ovr_set | (r_rx_overrun  & ~(w_wr_ctrl & wdata[CTRL_CLR_OVERRUN]));
            r_rdata_valid <= rd_en;
            if (rd_en) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign irq         = (w_rx_count != '0) | r_rx_overrun;

endmodule
